spi_top: RTL and testbench

SPI_TOP -- requirements
Module: spi_top

---
 rtl/spi_top.sv | 160 ++++++++++++++++
 tb/tb_spi_top.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/spi_top.sv
// SPI master with a four-register host interface (CTRL, CONFIG, SSELEC, BUFFER).
// Optional macro SPI_BUSY_STATUS_EN exposes the live busy flag on CTRL bit 7.
module spi_top (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [1:0] Addr,
  input  logic       Wr,
  input  logic [7:0] DataWr,
  output logic [7:0] DataRd,
  input  logic       MISO,
  output logic       MOSI,
  output logic       SCK,
  output logic [7:0] SlaveSelectors
);

  typedef enum logic {IDLE, XFER} state_e;

  state_e      state_q, state_d;
  logic        enable_q, enable_d;
  logic [1:0]  mode_q, mode_d;
  logic [3:0]  pre_q, pre_d;
  logic [7:0]  ssel_q, ssel_d;
  logic [7:0]  buffer_q, buffer_d;
  logic [7:0]  txShift_q, txShift_d;
  logic [7:0]  rxShift_q, rxShift_d;
  logic [3:0]  edgeCnt_q, edgeCnt_d;
  logic [3:0]  preCnt_q, preCnt_d;
  logic        sck_q, sck_d;
  logic        mosi_q, mosi_d;

  logic        wrCtrl, wrCfg, wrSsel, wrBuf;
  logic        leadingEdge;
  logic        busyBit;

  assign wrCtrl = Wr && (Addr == 2'd0);
  assign wrCfg  = Wr && (Addr == 2'd1);
  assign wrSsel = Wr && (Addr == 2'd2);
  assign wrBuf  = Wr && (Addr == 2'd3);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= IDLE;
      enable_q  <= 1'b0;
      mode_q    <= 2'd0;
      pre_q     <= 4'd0;
      ssel_q    <= 8'hFF;
      buffer_q  <= 8'd0;
      txShift_q <= 8'd0;
      rxShift_q <= 8'd0;
      edgeCnt_q <= 4'd0;
      preCnt_q  <= 4'd0;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      enable_q  <= enable_d;
      mode_q    <= mode_d;
      pre_q     <= pre_d;
      ssel_q    <= ssel_d;
      buffer_q  <= buffer_d;
      txShift_q <= txShift_d;
      rxShift_q <= rxShift_d;
      edgeCnt_q <= edgeCnt_d;
      preCnt_q  <= preCnt_d;
      sck_q     <= sck_d;
      mosi_q    <= mosi_d;
    end
  end

  // Each SCK toggle is counted as an edge 0..15; even edges are leading, odd are trailing.
  always_comb begin
    state_d     = state_q;
    enable_d    = enable_q;
    mode_d      = mode_q;
    pre_d       = pre_q;
    ssel_d      = ssel_q;
    buffer_d    = buffer_q;
    txShift_d   = txShift_q;
    rxShift_d   = rxShift_q;
    edgeCnt_d   = edgeCnt_q;
    preCnt_d    = preCnt_q;
    sck_d       = sck_q;
    mosi_d      = mosi_q;
    leadingEdge = ~edgeCnt_q[0];

    if (wrCtrl) enable_d = DataWr[0];
    if (wrSsel) ssel_d = DataWr;

    case (state_q)
      IDLE: begin
        if (wrCfg) begin
          mode_d = DataWr[5:4];
          pre_d  = DataWr[3:0];
        end
        sck_d = mode_d[1];
        if (wrBuf && enable_q) begin
          state_d   = XFER;
          txShift_d = DataWr;
          buffer_d  = DataWr;
          rxShift_d = 8'd0;
          edgeCnt_d = 4'd0;
          preCnt_d  = 4'd0;
          if (!mode_q[0]) mosi_d = DataWr[7];
        end
      end
      XFER: begin
        if (wrCtrl && !DataWr[0]) begin
          state_d   = IDLE;
          sck_d     = mode_q[1];
          edgeCnt_d = 4'd0;
          preCnt_d  = 4'd0;
        end else if (preCnt_q == pre_q) begin
          preCnt_d  = 4'd0;
          sck_d     = ~sck_q;
          edgeCnt_d = edgeCnt_q + 4'd1;
          if (leadingEdge ^ mode_q[0]) begin
            rxShift_d = {rxShift_q[6:0], MISO};
          end else if (mode_q[0]) begin
            mosi_d    = txShift_q[7];
            txShift_d = {txShift_q[6:0], 1'b0};
          end else if (edgeCnt_q != 4'd15) begin
            mosi_d    = txShift_q[6];
            txShift_d = {txShift_q[6:0], 1'b0};
          end
          // Final trailing edge: SCK is back at CPOL, so the byte is complete.
          if (edgeCnt_q == 4'd15) begin
            state_d   = IDLE;
            buffer_d  = rxShift_d;
            edgeCnt_d = 4'd0;
          end
        end else begin
          preCnt_d = preCnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef SPI_BUSY_STATUS_EN
  assign busyBit = (state_q == XFER);
`else
  assign busyBit = 1'b0;
`endif

  always_comb begin
    DataRd = 8'd0;
    case (Addr)
      2'd0: DataRd = {busyBit, 6'd0, enable_q};
      2'd1: DataRd = {2'd0, mode_q, pre_q};
      2'd2: DataRd = ssel_q;
      2'd3: DataRd = buffer_q;
      default: DataRd = 8'd0;
    endcase
  end

  assign SCK            = sck_q;
  assign MOSI           = mosi_q;
  assign SlaveSelectors = ssel_q;

endmodule

// File: tb/tb_spi_top.sv
// Randomized self-checking bench for spi_top with a behavioural SPI slave and
// an arithmetic SCK timing model (SCK toggles every PRE+1 cycles, 16 toggles).
module tb_spi_top;

  logic       Clk = 1'b0;
  logic       Rst;
  logic [1:0] Addr;
  logic       Wr;
  logic [7:0] DataWr;
  logic [7:0] DataRd;
  logic       MISO;
  logic       MOSI;
  logic       SCK;
  logic [7:0] SlaveSelectors;

  int   numChecks = 0;
  int   numFails  = 0;
  logic [7:0] rd;
  logic [7:0] slaveTx, slaveRx;
  logic       prevSck;

  spi_top dut (
    .Clk(Clk), .Rst(Rst), .Addr(Addr), .Wr(Wr), .DataWr(DataWr), .DataRd(DataRd),
    .MISO(MISO), .MOSI(MOSI), .SCK(SCK), .SlaveSelectors(SlaveSelectors)
  );

  always #5 Clk = ~Clk;

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    numChecks++;
    if (obs !== exp) begin
      numFails++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic writeReg(input logic [1:0] a, input logic [7:0] d);
    @(negedge Clk);
    Addr = a; DataWr = d; Wr = 1'b1;
    @(posedge Clk);
    #1 Wr = 1'b0;
  endtask

  task automatic readReg(input logic [1:0] a, output logic [7:0] d);
    Addr = a;
    #1 d = DataRd;
  endtask

  // Full transfer: SCK is checked every cycle against the timing formula, while
  // the slave model exchanges bytes on the SCK edges it observes.
  task automatic applyStimulus(input logic [1:0] mode, input logic [3:0] pre,
                               input logic [7:0] tx, input logic [7:0] reply,
                               input bit inject);
    int h, total;
    logic cpol, cpha, sckExp, lead, busyExp;
    h = int'(pre) + 1;
    total = 16 * h;
    cpol = mode[1];
    cpha = mode[0];
    writeReg(2'd1, {2'b00, mode, pre});
    readReg(2'd1, rd);
    checkOutput("cfg_readback", rd, {2'b00, mode, pre});
    checkOutput("sck_idle", {7'd0, SCK}, {7'd0, cpol});
    slaveTx = reply; slaveRx = 8'd0; MISO = reply[7]; prevSck = cpol;
    writeReg(2'd3, tx);
    if (!cpha) checkOutput("mosi_first", {7'd0, MOSI}, {7'd0, tx[7]});
    for (int t = 0; t <= total + 2; t++) begin
      sckExp = (t >= total) ? cpol : (cpol ^ ((t / h) % 2 == 1));
      checkOutput("sck_wave", {7'd0, SCK}, {7'd0, sckExp});
      busyExp = (t < total);
      readReg(2'd0, rd);
`ifdef SPI_BUSY_STATUS_EN
      checkOutput("busy", {7'd0, rd[7]}, {7'd0, busyExp});
`else
      checkOutput("ctrl_bit7", {7'd0, rd[7]}, 8'd0);
`endif
      if (SCK !== prevSck) begin
        lead = (SCK != cpol);
        if (lead ^ cpha) slaveRx = {slaveRx[6:0], MOSI};
        else if (cpha) begin MISO = slaveTx[7]; slaveTx = slaveTx << 1; end
        else begin slaveTx = slaveTx << 1; MISO = slaveTx[7]; end
        prevSck = SCK;
      end
      if (t == total) begin
        readReg(2'd3, rd);
        checkOutput("buffer_rx", rd, reply);
      end
      if (inject && t == 2) begin Addr = 2'd3; DataWr = 8'h11; Wr = 1'b1; end
      if (inject && t == 3) begin Addr = 2'd1; DataWr = 8'h33; Wr = 1'b1; end
      @(posedge Clk);
      #1 Wr = 1'b0;
    end
    checkOutput("slave_rx", slaveRx, tx);
    checkOutput("mosi_hold", {7'd0, MOSI}, {7'd0, tx[0]});
    readReg(2'd1, rd);
    checkOutput("cfg_kept", rd, {2'b00, mode, pre});
  endtask

  initial begin
    Rst = 1'b1; Wr = 1'b0; Addr = 2'd0; DataWr = 8'd0; MISO = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk) Rst = 1'b0;
    @(posedge Clk); #1;
    readReg(2'd0, rd); checkOutput("rst_ctrl", rd, 8'h00);
    readReg(2'd1, rd); checkOutput("rst_cfg", rd, 8'h00);
    readReg(2'd2, rd); checkOutput("rst_ssel", rd, 8'hFF);
    readReg(2'd3, rd); checkOutput("rst_buf", rd, 8'h00);
    checkOutput("rst_pins", {5'd0, SCK, MOSI, 1'b0}, 8'h00);
    checkOutput("rst_ss", SlaveSelectors, 8'hFF);

    writeReg(2'd0, 8'h01);
    readReg(2'd0, rd); checkOutput("ctrl_en", rd, 8'h01);
    writeReg(2'd2, 8'hFE);
    readReg(2'd2, rd); checkOutput("ssel_rd", rd, 8'hFE);
    checkOutput("ssel_pins", SlaveSelectors, 8'hFE);

    applyStimulus(2'd0, 4'd2, 8'hBB, 8'hAA, 1'b0);
    applyStimulus(2'd1, 4'd2, 8'hBB, 8'h72, 1'b0);
    applyStimulus(2'd2, 4'd2, 8'hBB, 8'hC3, 1'b0);
    applyStimulus(2'd3, 4'd2, 8'hBB, 8'h5D, 1'b0);
    applyStimulus(2'd0, 4'd2, 8'hBB, 8'h3C, 1'b1);
    applyStimulus(2'd3, 4'd2, 8'h96, 8'h69, 1'b1);
    applyStimulus(2'd1, 4'd0, 8'hA5, 8'h5A, 1'b0);
    applyStimulus(2'd2, 4'd15, 8'h81, 8'h7E, 1'b0);
    for (int i = 0; i < 8; i++)
      applyStimulus(2'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                    8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));

    // Abort by clearing enable mid-transfer.
    writeReg(2'd1, 8'h21);
    writeReg(2'd3, 8'hC7);
    repeat (5) @(posedge Clk);
    writeReg(2'd0, 8'h00);
    checkOutput("abort_sck", {7'd0, SCK}, 8'd1);
    readReg(2'd0, rd); checkOutput("abort_ctrl", rd, 8'h00);
    readReg(2'd3, rd); checkOutput("abort_buf", rd, 8'hC7);
    writeReg(2'd3, 8'h55);
    for (int t = 0; t < 12; t++) begin
      checkOutput("disabled_sck", {7'd0, SCK}, 8'd1);
      @(posedge Clk); #1;
    end
    readReg(2'd3, rd); checkOutput("disabled_buf", rd, 8'hC7);

    // Reset in the middle of a transfer.
    writeReg(2'd0, 8'h01);
    writeReg(2'd1, 8'h30);
    writeReg(2'd3, 8'hE4);
    repeat (4) @(posedge Clk);
    @(negedge Clk) Rst = 1'b1;
    @(posedge Clk);
    @(negedge Clk) Rst = 1'b0;
    #1;
    readReg(2'd3, rd); checkOutput("midrst_buf", rd, 8'h00);
    readReg(2'd1, rd); checkOutput("midrst_cfg", rd, 8'h00);
    readReg(2'd0, rd); checkOutput("midrst_ctrl", rd, 8'h00);
    checkOutput("midrst_pins", {5'd0, SCK, MOSI, 1'b0}, 8'h00);
    checkOutput("midrst_ss", SlaveSelectors, 8'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
